// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//  Shares one memory port between instruction fetch (read-only) and the MEM
//  stage (load/store). One transaction is in flight at a time; a 3-state FSM
//  (IDLE, IF_BUSY, DM_BUSY) sequences the req/ack handshake and the stall
//  outputs gate the pipeline register enables.
//
//  Ports
//   clk, reset            clock (rising edge), async active-low reset
//   if_req/if_addr        fetch request, held until if_valid
//   if_rdata/if_valid     fetched word and 1-cycle completion pulse
//   dm_req/we/addr/wdata/be  data request, held until dm_valid
//   dm_rdata/dm_valid     load word and 1-cycle completion pulse
//   mem_req/we/addr/wdata/be  memory request, stable until mem_ack
//   mem_rdata/mem_ack     memory response
//   stall_if, stall_mem   pipeline freeze controls
//   err                   sticky timeout flag
//
//  Optional feature: define ARB_TIMEOUT_EN to abort a transaction after
//  TIMEOUT busy cycles without ack. Without it err is tied to 0.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    input  logic [DW/8-1:0] dm_be,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_valid,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   grant_dm_s;
    logic   grant_if_s;
    logic   done_s;
    logic   abort_s;
    logic   timeout_hit_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] tmo_cnt_r;
    logic          err_r;

    // Busy-cycle counter: cleared on grant, advances while waiting for ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_r <= {CW{1'b0}};
        end else if (grant_dm_s || grant_if_s) begin
            tmo_cnt_r <= {CW{1'b0}};
        end else if ((state_r != IDLE) && !mem_ack) begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (abort_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign timeout_hit_s = (tmo_cnt_r == TMO_LAST);
    assign err           = err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign err           = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and grant/complete decode. A requester whose valid pulse is
    // visible this cycle is still holding its old request, so it is not
    // eligible; this also guarantees an idle cycle between transactions.
    always_comb begin
        state_nxt_s = state_r;
        grant_dm_s  = 1'b0;
        grant_if_s  = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (dm_req && !dm_valid) begin
                    grant_dm_s  = 1'b1;
                    state_nxt_s = DM_BUSY;
                end else if (if_req && !if_valid) begin
                    grant_if_s  = 1'b1;
                    state_nxt_s = IF_BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ack) begin
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else if (timeout_hit_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Memory port and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {DW{1'b0}};
            mem_be    <= {(DW/8){1'b0}};
            if_rdata  <= {DW{1'b0}};
            dm_rdata  <= {DW{1'b0}};
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if (grant_dm_s) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                mem_be    <= dm_be;
            end else if (grant_if_s) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= {DW{1'b0}};
                mem_be    <= {(DW/8){1'b0}};
            end else if (done_s) begin
                mem_req <= 1'b0;
                if (state_r == IF_BUSY) begin
                    if_rdata <= mem_rdata;
                    if_valid <= 1'b1;
                end else begin
                    // Stores leave the previous load data visible
                    if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                    end
                    dm_valid <= 1'b1;
                end
            end else if (abort_s) begin
                mem_req <= 1'b0;
                if (state_r == IF_BUSY) begin
                    if_rdata <= {DW{1'b0}};
                    if_valid <= 1'b1;
                end else begin
                    dm_rdata <= {DW{1'b0}};
                    dm_valid <= 1'b1;
                end
            end
        end
    end

    assign stall_mem = dm_req & ~dm_valid;
    assign stall_if  = (if_req & ~if_valid) | stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic [3:0]  dm_be = 4'h0;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    always #5 clk = ~clk;

    // memory image for the random test; unwritten words have a fixed pattern
    logic [31:0] mem_m [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) cyc();
        checks++;
        if ({mem_req, mem_we, if_valid, dm_valid, err, stall_if, stall_mem} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 0", {mem_req, mem_we, if_valid, dm_valid, err, stall_if, stall_mem});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata} !== 132'b0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata});
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL idle_req cycle %0d: got %b expected 0", i, mem_req);
            end
        end
    endtask

    task automatic test_fetch_zero_wait();
        if_req = 1'b1; if_addr = 32'h40; mem_rdata = 32'h8C01_0004; mem_ack = 1'b0;
        #1;
        checks++;
        if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall0: got %b expected 1", stall_if); end
        cyc();
        checks++;
        if ({mem_req, mem_we, mem_addr, stall_if} !== {1'b1, 1'b0, 32'h40, 1'b1}) begin
            errors++;
            $display("FAIL fetch_grant: got req=%b we=%b addr=%h stall=%b expected 1 0 00000040 1", mem_req, mem_we, mem_addr, stall_if);
        end
        mem_ack = 1'b1;
        cyc();
        checks++;
        if ({if_valid, if_rdata, stall_if, mem_req} !== {1'b1, 32'h8C01_0004, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fetch_done: got v=%b d=%h stall=%b req=%b expected 1 8c010004 0 0", if_valid, if_rdata, stall_if, mem_req);
        end
        if_req = 1'b0; mem_ack = 1'b0;
        cyc();
        checks++;
        if (if_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got %b expected 0", if_valid); end
    endtask

    task automatic test_contention();
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; mem_ack = 1'b0;
        cyc();
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL cont_first: got req=%b we=%b addr=%h expected 1 0 00000100", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        cyc();
        checks++;
        if ({dm_valid, dm_rdata, if_valid, mem_req} !== {1'b1, 32'h1111_2222, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL cont_dm_done: got dv=%b d=%h iv=%b req=%b expected 1 11112222 0 0", dm_valid, dm_rdata, if_valid, mem_req);
        end
        // ack stays high through the idle cycle and must not complete anything
        dm_req = 1'b0; mem_rdata = 32'h3333_4444;
        cyc();
        checks++;
        if ({mem_req, mem_addr, if_valid, dm_valid} !== {1'b1, 32'h40, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL cont_second: got req=%b addr=%h iv=%b dv=%b expected 1 00000040 0 0", mem_req, mem_addr, if_valid, dm_valid);
        end
        cyc();
        checks++;
        if ({if_valid, if_rdata, dm_valid} !== {1'b1, 32'h3333_4444, 1'b0}) begin
            errors++;
            $display("FAIL cont_if_done: got iv=%b d=%h dv=%b expected 1 33334444 0", if_valid, if_rdata, dm_valid);
        end
        if_req = 1'b0; mem_ack = 1'b0;
        cyc();
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b1111;
        mem_rdata = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, dm_valid} !== {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
                errors++;
                $display("FAIL store_hold %0d: got req=%b we=%b a=%h d=%h be=%h dv=%b expected 1 1 00000200 deadbeef f 0",
                         i, mem_req, mem_we, mem_addr, mem_wdata, mem_be, dm_valid);
            end
            if (i == 3) mem_ack = 1'b1;
        end
        cyc();
        checks++;
        if ({dm_valid, dm_rdata, stall_mem, mem_req} !== {1'b1, 32'h1111_2222, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL store_done: got dv=%b d=%h stall=%b req=%b expected 1 11112222 0 0", dm_valid, dm_rdata, stall_mem, mem_req);
        end
        dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        cyc();
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_grant: got %b expected 1", mem_req); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, dm_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_drop: got req=%b dv=%b expected 0 0", mem_req, dm_valid);
        end
        dm_req = 1'b0;
        @(negedge clk);
        reset = 1'b1; mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({mem_req, dm_valid} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_late_ack %0d: got req=%b dv=%b expected 0 0", i, mem_req, dm_valid);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_random();
        int          owner = 0;      // 0 none, 1 fetch, 2 data
        int          done_owner;
        int          expect_grant;
        int          wait_left = 0;
        logic        prev_req = 1'b0, prev_ack = 1'b0;
        logic        elig_if = 1'b0, elig_dm = 1'b0;
        logic        if_pend = 1'b0, dm_pend = 1'b0;
        logic [31:0] exp_data = 32'h0, last_dm = 32'h0, own_addr = 32'h0, w;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; mem_ack = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        for (int c = 0; c < 600; c++) begin
            cyc();
            done_owner = 0;
            // completion expected only for an ack seen while a request was up
            if (prev_req && prev_ack) begin
                done_owner = owner;
                checks++;
                if (owner == 1) begin
                    if ({if_valid, dm_valid, if_rdata, mem_req} !== {1'b1, 1'b0, exp_data, 1'b0}) begin
                        errors++;
                        $display("FAIL rnd_if_done c%0d: got iv=%b dv=%b d=%h req=%b expected 1 0 %h 0", c, if_valid, dm_valid, if_rdata, mem_req, exp_data);
                    end
                end else begin
                    if (!dm_we) last_dm = exp_data;
                    if ({dm_valid, if_valid, dm_rdata, mem_req} !== {1'b1, 1'b0, last_dm, 1'b0}) begin
                        errors++;
                        $display("FAIL rnd_dm_done c%0d: got dv=%b iv=%b d=%h req=%b expected 1 0 %h 0", c, dm_valid, if_valid, dm_rdata, mem_req, last_dm);
                    end
                end
                owner = 0;
            end else begin
                checks++;
                if ({if_valid, dm_valid} !== 2'b00) begin
                    errors++;
                    $display("FAIL rnd_spurious_valid c%0d: got iv=%b dv=%b expected 0 0", c, if_valid, dm_valid);
                end
            end
            if (!prev_req) begin
                // port was idle at the last edge: data requester has priority
                expect_grant = elig_dm ? 2 : (elig_if ? 1 : 0);
                checks++;
                if (expect_grant == 0) begin
                    if (mem_req !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd_no_grant c%0d: got req=%b expected 0", c, mem_req);
                    end
                end else if (expect_grant == 2) begin
                    if ({mem_req, mem_we, mem_addr} !== {1'b1, dm_we, dm_addr} ||
                        (dm_we && {mem_wdata, mem_be} !== {dm_wdata, dm_be})) begin
                        errors++;
                        $display("FAIL rnd_dm_grant c%0d: got req=%b we=%b a=%h d=%h be=%h expected 1 %b %h %h %h",
                                 c, mem_req, mem_we, mem_addr, mem_wdata, mem_be, dm_we, dm_addr, dm_wdata, dm_be);
                    end
                end else begin
                    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, if_addr}) begin
                        errors++;
                        $display("FAIL rnd_if_grant c%0d: got req=%b we=%b a=%h expected 1 0 %h", c, mem_req, mem_we, mem_addr, if_addr);
                    end
                end
                if (expect_grant != 0) begin
                    owner = expect_grant;
                    own_addr = (owner == 2) ? dm_addr : if_addr;
                    wait_left = $urandom_range(0, 3);
                end
            end else if (!prev_ack) begin
                checks++;
                if ({mem_req, mem_addr} !== {1'b1, own_addr}) begin
                    errors++;
                    $display("FAIL rnd_hold c%0d: got req=%b a=%h expected 1 %h", c, mem_req, mem_addr, own_addr);
                end
            end
            // requesters: retire on completion, occasionally issue new work
            if (done_owner == 1) begin if_pend = 1'b0; if_req = 1'b0; end
            if (done_owner == 2) begin dm_pend = 1'b0; dm_req = 1'b0; end
            if (c < 560 && !if_pend && ($urandom_range(0, 2) == 0)) begin
                if_pend = 1'b1; if_req = 1'b1;
                if_addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            end
            if (c < 560 && !dm_pend && ($urandom_range(0, 2) == 0)) begin
                dm_pend = 1'b1; dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
                dm_wdata = $urandom; dm_be = 4'($urandom_range(0, 15));
            end
            elig_if = if_req && !if_valid;
            elig_dm = dm_req && !dm_valid;
            // memory responder
            if (mem_req) begin
                mem_rdata = rd(mem_addr);
                if (wait_left == 0) begin
                    mem_ack = 1'b1;
                    exp_data = rd(own_addr);
                    if (owner == 2 && dm_we) begin
                        w = rd(own_addr);
                        for (int b = 0; b < 4; b++) if (dm_be[b]) w[8*b +: 8] = dm_wdata[8*b +: 8];
                        mem_m[own_addr] = w;
                    end
                end else begin
                    mem_ack = 1'b0;
                    wait_left--;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            prev_req = mem_req;
            prev_ack = mem_ack;
            #1;
            checks++;
            if ({stall_mem, stall_if, err} !== {elig_dm, elig_dm || elig_if, 1'b0}) begin
                errors++;
                $display("FAIL rnd_stall c%0d: got sm=%b si=%b err=%b expected %b %b 0", c, stall_mem, stall_if, err, elig_dm, elig_dm || elig_if);
            end
        end
        if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
        cyc();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if ({mem_req, err, dm_valid} !== 3'b100) begin
                errors++;
                $display("FAIL tmo_busy %0d: got req=%b err=%b dv=%b expected 1 0 0", i, mem_req, err, dm_valid);
            end
        end
        cyc();
        checks++;
        if ({mem_req, err, dm_valid, dm_rdata} !== {3'b011, 32'h0}) begin
            errors++;
            $display("FAIL tmo_abort: got req=%b err=%b dv=%b d=%h expected 0 1 1 0", mem_req, err, dm_valid, dm_rdata);
        end
        dm_req = 1'b0;
        repeat (3) cyc();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", err); end
        reset = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", err); end
        @(negedge clk);
        reset = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_contention();
        test_store();
        test_reset_mid();
        test_random();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
